axi2rib_bridge: RTL and testbench

AXI4-Lite slave to RIB master bridge. Lets an external AXI4-Lite initiator (ysyxSoC-side debugger/DMA/loader) read and write every RIB slave (rom, ram, timer, uart, gpio, spi) through RIB master port 3, the highest-priority port, which is free in the ysyx build. It is the reverse direction of the planned rib2axi path. It converts single-beat AXI transactions into word-wide RIB accesses and performs read-modify-write for partial byte strobes.

---
 rtl/axi_lite_pkg.sv | 32 +++
 rtl/axi_hold_reg.sv | 31 +++
 rtl/axi2rib_bridge.sv | 170 +++++++++++++++++
 tb/tb_axi2rib_bridge.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite to RIB bridge.
// RIB bus widths, AXI response codes and the bridge FSM encoding.
package axi_lite_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    RMW_RD,
    WR_REQ,
    WR_RESP
  } state_e;

  function automatic logic [MEM_DATA_W-1:0] merge_bytes(
    input logic [MEM_DATA_W-1:0] nw,
    input logic [MEM_DATA_W-1:0] old,
    input logic [3:0]            strb
  );
    logic [MEM_DATA_W-1:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_hold_reg.sv
// One-entry valid/ready holding register for an AXI request channel.
// Accepts only while enabled and empty; emptied by an explicit clear.
module axi_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] data,
  output logic         ready,
  output logic         held,
  output logic [W-1:0] q
);

  assign ready = en && !held;

  always_ff @(posedge clk) begin
    if (rst) begin
      held <= 1'b0;
      q    <= '0;
    end else if (clr) begin
      held <= 1'b0;
    end else if (valid && ready) begin
      held <= 1'b1;
      q    <= data;
    end
  end

endmodule

// File: rtl/axi2rib_bridge.sv
// AXI4-Lite slave to RIB master bridge (RIB master port 3).
// Single-beat accesses; partial strobes use read-modify-write.
import axi_lite_pkg::*;

module axi2rib_bridge #(
  parameter int RIB_LAT    = 1,
  parameter int NUM_SLAVES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  output logic        busy_o
);

  localparam logic [3:0] LAST = 4'(RIB_LAT - 1);
  localparam logic [4:0] NS   = 5'(NUM_SLAVES);

  state_e state, state_d;
  logic [3:0]  cnt;
  logic        last_wr;
  logic [31:0] rdata_q, old_q;
  logic [1:0]  rresp_q, bresp_q;

  logic        aw_held, w_held, ar_held;
  logic [31:0] aw_q, ar_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        idle, clr_ar, clr_w;
  logic        pick_wr, pick_rd, sub_last;
  logic        aw_ok, ar_ok;
  logic [31:0] merged;

  assign idle     = state == IDLE;
  assign sub_last = cnt == LAST;
  assign aw_ok    = {1'b0, aw_q[31:28]} < NS;
  assign ar_ok    = {1'b0, ar_q[31:28]} < NS;
  assign merged   = merge_bytes(wdata_q, old_q, wstrb_q);

  // Ties alternate; last_wr resets high so a read wins the first tie.
  assign pick_wr = aw_held && w_held && (!ar_held || !last_wr);
  assign pick_rd = ar_held && !pick_wr;

  axi_hold_reg #(.W(32)) u_aw (
    .clk(clk), .rst(rst), .valid(s_awvalid), .en(idle),
    .clr(clr_w), .data(s_awaddr), .ready(s_awready),
    .held(aw_held), .q(aw_q)
  );

  axi_hold_reg #(.W(36)) u_w (
    .clk(clk), .rst(rst), .valid(s_wvalid), .en(idle),
    .clr(clr_w), .data({s_wstrb, s_wdata}), .ready(s_wready),
    .held(w_held), .q({wstrb_q, wdata_q})
  );

  axi_hold_reg #(.W(32)) u_ar (
    .clk(clk), .rst(rst), .valid(s_arvalid), .en(idle),
    .clr(clr_ar), .data(s_araddr), .ready(s_arready),
    .held(ar_held), .q(ar_q)
  );

  always_comb begin
    state_d = state;
    req_o   = 1'b0;
    we_o    = 1'b0;
    addr_o  = '0;
    data_o  = '0;
    clr_ar  = 1'b0;
    clr_w   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_rd) begin
          state_d = ar_ok ? RD_REQ : RD_RESP;
        end else if (pick_wr) begin
          if (!aw_ok || wstrb_q == 4'h0) state_d = WR_RESP;
          else if (wstrb_q == 4'hF)      state_d = WR_REQ;
          else                           state_d = RMW_RD;
        end
      end
      RD_REQ: begin
        req_o  = 1'b1;
        addr_o = ar_q & 32'hFFFF_FFFC;
        if (sub_last) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (s_rready) begin
          clr_ar  = 1'b1;
          state_d = IDLE;
        end
      end
      RMW_RD: begin
        req_o  = 1'b1;
        addr_o = aw_q & 32'hFFFF_FFFC;
        if (sub_last) state_d = WR_REQ;
      end
      WR_REQ: begin
        req_o  = 1'b1;
        we_o   = 1'b1;
        addr_o = aw_q & 32'hFFFF_FFFC;
        data_o = merged;
        if (sub_last) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          clr_w   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_wr <= 1'b1;
      rdata_q <= '0;
      old_q   <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? 4'd0 : cnt + 4'd1;
      if (idle && pick_rd) begin
        last_wr <= 1'b0;
        if (!ar_ok) begin
          rresp_q <= RESP_SLVERR;
          rdata_q <= '0;
        end
      end
      if (idle && pick_wr) begin
        last_wr <= 1'b1;
        bresp_q <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (state == RD_REQ && sub_last) begin
        rdata_q <= data_i;
        rresp_q <= RESP_OKAY;
      end
      if (state == RMW_RD && sub_last) old_q <= data_i;
    end
  end

  assign s_rvalid = state == RD_RESP;
  assign s_bvalid = state == WR_RESP;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;
  assign s_bresp  = bresp_q;
  assign busy_o   = !idle;

endmodule

// File: tb/tb_axi2rib_bridge.sv
// Self-checking bench for axi2rib_bridge: table vectors, corner
// sequences and random traffic against a word-memory reference model.
module tb_axi2rib_bridge;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready, arvalid, arready;
  logic        rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [31:0] araddr, rdata;
  logic        req, we, busy;
  logic [31:0] addr, wdo, rdi;

  logic        l3_rst;
  logic        l3_awvalid, l3_awready, l3_wvalid, l3_wready;
  logic [31:0] l3_awaddr, l3_wdata;
  logic [3:0]  l3_wstrb;
  logic        l3_bvalid, l3_bready, l3_arvalid, l3_arready;
  logic        l3_rvalid, l3_rready;
  logic [1:0]  l3_bresp, l3_rresp;
  logic [31:0] l3_araddr, l3_rdata;
  logic        l3_req, l3_we, l3_busy;
  logic [31:0] l3_addr, l3_wdo, l3_rdi;

  logic [31:0] smem [128];
  logic [31:0] ref_mem [128];
  logic [31:0] last_wr;
  int req_cnt = 0;
  int l3_req_cnt = 0;
  int n_pass = 0;
  int n_total = 0;

  function automatic int idx(input logic [31:0] a);
    return int'({a[30:28], a[5:2]});
  endfunction

  assign rdi    = smem[idx(addr)];
  assign l3_rdi = smem[idx(l3_addr)];

  axi2rib_bridge #(.RIB_LAT(1), .NUM_SLAVES(6)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(awvalid), .s_awready(awready), .s_awaddr(awaddr),
    .s_wvalid(wvalid), .s_wready(wready),
    .s_wdata(wdata), .s_wstrb(wstrb),
    .s_bvalid(bvalid), .s_bready(bready), .s_bresp(bresp),
    .s_arvalid(arvalid), .s_arready(arready), .s_araddr(araddr),
    .s_rvalid(rvalid), .s_rready(rready),
    .s_rdata(rdata), .s_rresp(rresp),
    .req_o(req), .we_o(we), .addr_o(addr), .data_o(wdo),
    .data_i(rdi), .busy_o(busy)
  );

  axi2rib_bridge #(.RIB_LAT(3), .NUM_SLAVES(6)) dut3 (
    .clk(clk), .rst(l3_rst),
    .s_awvalid(l3_awvalid), .s_awready(l3_awready),
    .s_awaddr(l3_awaddr),
    .s_wvalid(l3_wvalid), .s_wready(l3_wready),
    .s_wdata(l3_wdata), .s_wstrb(l3_wstrb),
    .s_bvalid(l3_bvalid), .s_bready(l3_bready),
    .s_bresp(l3_bresp),
    .s_arvalid(l3_arvalid), .s_arready(l3_arready),
    .s_araddr(l3_araddr),
    .s_rvalid(l3_rvalid), .s_rready(l3_rready),
    .s_rdata(l3_rdata), .s_rresp(l3_rresp),
    .req_o(l3_req), .we_o(l3_we), .addr_o(l3_addr),
    .data_o(l3_wdo), .data_i(l3_rdi), .busy_o(l3_busy)
  );

  // RIB slave: word memory, access counters, last write seen.
  initial begin
    for (int i = 0; i < 128; i++) smem[i] = {8'(i), ~8'(i), 16'hC0DE};
    smem[idx(32'h1000_0004)] = 32'hDEAD_BEEF;
    smem[idx(32'h3000_0008)] = 32'hAABB_CCDD;
    forever begin
      @(posedge clk);
      if (req) req_cnt++;
      if (l3_req) l3_req_cnt++;
      if (req && we) begin
        smem[idx(addr)] = wdo;
        last_wr = wdo;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && !req) chk("bus_idle_zero", addr | wdo, 32'h0);
    if (!rst && req) chk("addr_aligned", {30'h0, addr[1:0]}, 32'h0);
  end

  function automatic logic pick(input int sel);
    case (sel)
      0: return req;
      1: return rvalid;
      2: return bvalid;
      3: return l3_req;
      4: return l3_rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_on(input int sel, input string name);
    int n = 0;
    while (!pick(sel) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!pick(sel)) begin
      n_total++;
      $display("FAIL %s: still low after %0d cycles, want high", name, n);
    end
  endtask

  // Reference: slave decode, word memory and byte-merge rules.
  task automatic model(input bit wr, input logic [31:0] a, d,
                       input logic [3:0] s, output logic [1:0] resp,
                       output logic [31:0] rd, output int reqs);
    int k;
    k = idx(a);
    resp = 2'b00;
    rd = 32'h0;
    reqs = 0;
    if (a[31:28] >= 4'd6) begin
      resp = 2'b10;
    end else if (!wr) begin
      rd = ref_mem[k];
      reqs = 1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[k][8*b +: 8] = d[8*b +: 8];
      if (s == 4'hF) reqs = 1;
      else if (s != 4'h0) reqs = 2;
    end
  endtask

  task automatic xact(input bit wr, input logic [31:0] a, d,
                      input logic [3:0] s, output logic [1:0] resp,
                      output logic [31:0] rd, output int reqs);
    int c0;
    logic aw_hs, w_hs, ar_hs;
    c0 = req_cnt;
    rd = 32'h0;
    if (wr) begin
      awvalid = 1; awaddr = a;
      wvalid = 1; wdata = d; wstrb = s;
      for (int i = 0; i < 64 && (awvalid || wvalid); i++) begin
        aw_hs = awvalid && awready;
        w_hs = wvalid && wready;
        @(negedge clk);
        if (aw_hs) awvalid = 0;
        if (w_hs) wvalid = 0;
      end
      awvalid = 0; wvalid = 0;
      wait_on(2, "bvalid_wait");
      resp = bresp;
      bready = 1;
      @(negedge clk);
      bready = 0;
    end else begin
      arvalid = 1; araddr = a;
      for (int i = 0; i < 64 && arvalid; i++) begin
        ar_hs = arready;
        @(negedge clk);
        if (ar_hs) arvalid = 0;
      end
      arvalid = 0;
      wait_on(1, "rvalid_wait");
      resp = rresp;
      rd = rdata;
      rready = 1;
      @(negedge clk);
      rready = 0;
    end
    reqs = req_cnt - c0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  resp;
    logic [31:0] rd;
    int          reqs;
    logic [31:0] wv;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [1:0]  r;
    logic [31:0] v, er;
    logic [1:0]  eresp;
    int          nq, eq, c0;
    bit          wr;
    logic [31:0] a, d;
    logic [3:0]  s;

    tbl[0] = '{0, 32'h1000_0004, 0, 0, 2'b00, 32'hDEAD_BEEF, 1, 0};
    tbl[1] = '{1, 32'h2000_0004, 32'h8765_4321, 4'hF,
               2'b00, 0, 1, 32'h8765_4321};
    tbl[2] = '{0, 32'h2000_0004, 0, 0, 2'b00, 32'h8765_4321, 1, 0};
    tbl[3] = '{1, 32'h3000_0008, 32'h1122_3344, 4'b0101,
               2'b00, 0, 2, 32'hAA22_CC44};
    tbl[4] = '{0, 32'h3000_0008, 0, 0, 2'b00, 32'hAA22_CC44, 1, 0};
    tbl[5] = '{0, 32'h7000_0000, 0, 0, 2'b10, 32'h0, 0, 0};
    tbl[6] = '{1, 32'h6000_0000, 32'h5555_AAAA, 4'hF, 2'b10, 0, 0, 0};
    tbl[7] = '{1, 32'h1000_0004, 32'hFFFF_FFFF, 4'h0, 2'b00, 0, 0, 0};
    tbl[8] = '{0, 32'h1000_0004, 0, 0, 2'b00, 32'hDEAD_BEEF, 1, 0};
    tbl[9] = '{0, 32'h5000_0000, 0, 0, 2'b00, 32'h50AF_C0DE, 1, 0};

    for (int i = 0; i < 128; i++) ref_mem[i] = {8'(i), ~8'(i), 16'hC0DE};
    ref_mem[idx(32'h1000_0004)] = 32'hDEAD_BEEF;
    ref_mem[idx(32'h3000_0008)] = 32'hAABB_CCDD;

    rst = 1; l3_rst = 1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    l3_awvalid = 0; l3_wvalid = 0; l3_arvalid = 0;
    l3_bready = 0; l3_rready = 0;
    l3_awaddr = 0; l3_wdata = 0; l3_wstrb = 0; l3_araddr = 0;
    repeat (3) @(negedge clk);
    rst = 0; l3_rst = 0;

    chk("rst_readies", {29'h0, awready, wready, arready}, 32'h7);
    chk("rst_valids", {30'h0, bvalid, rvalid}, 32'h0);
    chk("rst_resps", {28'h0, bresp, rresp}, 32'h0);
    chk("rst_req_we_busy", {29'h0, req, we, busy}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_data", wdo, 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    // Tie after reset: read first, then write; both stalled 5 cycles.
    c0 = req_cnt;
    arvalid = 1; araddr = 32'h1000_0004;
    awvalid = 1; awaddr = 32'h4000_0000;
    wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    @(negedge clk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    wait_on(0, "arb_first_req");
    chk("arb_first_is_read", {31'h0, we}, 32'h0);
    chk("arb_first_addr", addr, 32'h1000_0004);
    wait_on(1, "arb_rvalid");
    for (int i = 0; i < 5; i++) begin
      chk("arb_rvalid_stall", {31'h0, rvalid}, 32'h1);
      chk("arb_rdata_stall", rdata, 32'hDEAD_BEEF);
      chk("arb_no_req_stall", {31'h0, req}, 32'h0);
      @(negedge clk);
    end
    rready = 1; @(negedge clk); rready = 0;
    wait_on(0, "arb_second_req");
    chk("arb_second_we", {31'h0, we}, 32'h1);
    chk("arb_second_addr", addr, 32'h4000_0000);
    chk("arb_second_data", wdo, 32'hCAFE_F00D);
    wait_on(2, "arb_bvalid");
    for (int i = 0; i < 5; i++) begin
      chk("arb_bvalid_stall", {31'h0, bvalid}, 32'h1);
      chk("arb_bresp_stall", {30'h0, bresp}, 32'h0);
      @(negedge clk);
    end
    bready = 1; @(negedge clk); bready = 0;
    chk("arb_req_count", req_cnt - c0, 2);
    model(1, 32'h4000_0000, 32'hCAFE_F00D, 4'hF, r, v, nq);

    // Read latency: handshake in N, rvalid in N+3.
    arvalid = 1; araddr = 32'h1000_0004;
    chk("lat_arready", {31'h0, arready}, 32'h1);
    @(negedge clk); arvalid = 0;
    chk("lat_n1_arready", {31'h0, arready}, 32'h0);
    chk("lat_n1_req_rvalid", {30'h0, req, rvalid}, 32'h0);
    @(negedge clk);
    chk("lat_n2_req_we", {30'h0, req, we}, 32'h2);
    chk("lat_n2_addr", addr, 32'h1000_0004);
    chk("lat_n2_rvalid", {31'h0, rvalid}, 32'h0);
    @(negedge clk);
    chk("lat_n3_rvalid_req", {30'h0, rvalid, req}, 32'h2);
    chk("lat_n3_rdata", rdata, 32'hDEAD_BEEF);
    chk("lat_n3_rresp", {30'h0, rresp}, 32'h0);
    rready = 1; @(negedge clk); rready = 0;
    chk("lat_rvalid_drop", {31'h0, rvalid}, 32'h0);

    // Full write, W two cycles ahead of AW; bvalid in N+3.
    c0 = req_cnt;
    wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF;
    chk("fw_wready", {31'h0, wready}, 32'h1);
    @(negedge clk); wvalid = 0;
    chk("fw_w_held", {31'h0, wready}, 32'h0);
    chk("fw_not_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    awvalid = 1; awaddr = 32'h2000_0000;
    chk("fw_awready", {31'h0, awready}, 32'h1);
    @(negedge clk); awvalid = 0;
    chk("fw_n1", {30'h0, req, bvalid}, 32'h0);
    @(negedge clk);
    chk("fw_n2_req_we", {30'h0, req, we}, 32'h3);
    chk("fw_n2_addr", addr, 32'h2000_0000);
    chk("fw_n2_data", wdo, 32'h1234_5678);
    @(negedge clk);
    chk("fw_n3_bvalid", {31'h0, bvalid}, 32'h1);
    chk("fw_n3_bresp", {30'h0, bresp}, 32'h0);
    bready = 1; @(negedge clk); bready = 0;
    chk("fw_one_access", req_cnt - c0, 1);
    model(1, 32'h2000_0000, 32'h1234_5678, 4'hF, r, v, nq);

    for (int i = 0; i < 10; i++) begin
      model(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, eresp, er, eq);
      xact(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, r, v, nq);
      chk($sformatf("tbl%0d_resp", i), {30'h0, r}, {30'h0, tbl[i].resp});
      chk($sformatf("tbl%0d_reqs", i), nq, tbl[i].reqs);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), v, tbl[i].rd);
      if (tbl[i].wr && tbl[i].reqs > 0)
        chk($sformatf("tbl%0d_wdata", i), last_wr, tbl[i].wv);
    end

    // Reset mid-write on the RIB_LAT=3 bridge.
    l3_awvalid = 1; l3_awaddr = 32'h1000_0000;
    l3_wvalid = 1; l3_wdata = 32'h0BAD_0BAD; l3_wstrb = 4'hF;
    @(negedge clk);
    l3_awvalid = 0; l3_wvalid = 0;
    wait_on(3, "l3_wr_req");
    chk("l3_in_wr_req", {31'h0, l3_we}, 32'h1);
    l3_rst = 1;
    @(negedge clk);
    chk("l3_req_dropped", {31'h0, l3_req}, 32'h0);
    chk("l3_no_bvalid", {31'h0, l3_bvalid}, 32'h0);
    chk("l3_readies", {29'h0, l3_awready, l3_wready, l3_arready}, 32'h7);
    chk("l3_idle", {31'h0, l3_busy}, 32'h0);
    l3_rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("l3_quiet", {29'h0, l3_bvalid, l3_req, l3_busy}, 32'h0);
    end
    c0 = l3_req_cnt;
    l3_arvalid = 1; l3_araddr = 32'h1000_0004;
    @(negedge clk); l3_arvalid = 0;
    wait_on(4, "l3_rvalid");
    chk("l3_rdata", l3_rdata, 32'hDEAD_BEEF);
    chk("l3_rresp", {30'h0, l3_rresp}, 32'h0);
    chk("l3_req_cycles", l3_req_cnt - c0, 3);
    l3_rready = 1; @(negedge clk); l3_rready = 0;

    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom);
      a = {1'b0, 3'($urandom_range(0, 7)), 22'h0,
           4'($urandom), 2'($urandom)};
      d = $urandom;
      s = 4'($urandom);
      model(wr, a, d, s, eresp, er, eq);
      xact(wr, a, d, s, r, v, nq);
      chk($sformatf("rnd%0d_resp", i), {30'h0, r}, {30'h0, eresp});
      chk($sformatf("rnd%0d_reqs", i), nq, eq);
      if (!wr) chk($sformatf("rnd%0d_rdata", i), v, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
